// File: rtl/flappy_game_ctrl.sv
// ---------------------------------------------------------------------------
// flappy_game_ctrl
// Game sequencer that sits between the keyboard/frame-tick logic and the
// buildings/bird units. It runs the idle/play/slow/hit/over state machine and
// keeps track of lives, score and the slow-motion budget.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start_of_frame             one-cycle pulse per video frame
//   start_key, slow_key        synchronized key levels (rising-edge detected)
//   stage                      stage count from the buildings unit
//   collision_bird_building    bird overlaps a building (level)
//   collision_bird_ground      bird touches ground/ceiling (level)
//   destructed_building_1/2    building destroyed flags (rising-edge detected)
//   slow_down, freeze          motion control to buildings / bird units
//   game_over                  high while in OVER
//   score, lives, slow_left    game counters
//   state                      IDLE=0 PLAY=1 SLOW=2 HIT=3 OVER=4
// ---------------------------------------------------------------------------
module flappy_game_ctrl #(
    parameter int LIVES         = 3,
    parameter int SLOW_BUDGET   = 3,
    parameter int SLOW_FRAMES   = 120,
    parameter int HIT_FRAMES    = 60,
    parameter int INVULN_FRAMES = 90,
    parameter int DESTROY_BONUS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_of_frame,
    input  logic        start_key,
    input  logic        slow_key,
    input  logic [31:0] stage,
    input  logic        collision_bird_building,
    input  logic        collision_bird_ground,
    input  logic        destructed_building_1,
    input  logic        destructed_building_2,
    output logic        slow_down,
    output logic        freeze,
    output logic        game_over,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [3:0]  slow_left,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        SLOW = 3'd2,
        HIT  = 3'd3,
        OVER = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  lives_q, lives_d;
    logic [3:0]  slow_left_q, slow_left_d;
    logic [7:0]  slow_timer_q, slow_timer_d;
    logic [7:0]  hit_timer_q, hit_timer_d;
    logic [7:0]  invuln_timer_q, invuln_timer_d;

    // Delayed copies for edge detection
    logic        start_key_q, slow_key_q, destr1_q, destr2_q;
    logic [31:0] stage_q;

    logic start_edge, slow_edge, destr1_edge, destr2_edge, stage_chg, hit;

    // Clamp an 18-bit sum to the 16-bit score range
    function automatic logic [15:0] sat16(input logic [17:0] v);
        return (v > 18'h0FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    assign start_edge  = start_key & ~start_key_q;
    assign slow_edge   = slow_key & ~slow_key_q;
    assign destr1_edge = destructed_building_1 & ~destr1_q;
    assign destr2_edge = destructed_building_2 & ~destr2_q;
    assign stage_chg   = (stage != stage_q);
    assign hit         = (collision_bird_building | collision_bird_ground) &&
                         (invuln_timer_q == 8'd0);

    always_comb begin
        logic [17:0] sum;
        state_d        = state_q;
        score_d        = score_q;
        lives_d        = lives_q;
        slow_left_d    = slow_left_q;
        slow_timer_d   = slow_timer_q;
        hit_timer_d    = hit_timer_q;
        invuln_timer_d = invuln_timer_q;
        sum = {2'b00, score_q} + {17'd0, stage_chg}
            + (destr1_edge ? 18'(DESTROY_BONUS) : 18'd0)
            + (destr2_edge ? 18'(DESTROY_BONUS) : 18'd0);

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d        = PLAY;
                    score_d        = 16'd0;
                    lives_d        = 3'(LIVES);
                    slow_left_d    = 4'(SLOW_BUDGET);
                    invuln_timer_d = 8'd0;
                end
            end
            PLAY, SLOW: begin
                // Scoring uses the current state, so a hit cycle still scores
                score_d = sat16(sum);
                if (start_of_frame && invuln_timer_q != 8'd0)
                    invuln_timer_d = invuln_timer_q - 8'd1;
                if (hit) begin
                    state_d      = HIT;
                    lives_d      = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                    hit_timer_d  = 8'(HIT_FRAMES);
                    slow_timer_d = 8'd0;
                end else if (state_q == PLAY) begin
                    if (slow_edge && slow_left_q != 4'd0) begin
                        state_d      = SLOW;
                        slow_left_d  = slow_left_q - 4'd1;
                        slow_timer_d = 8'(SLOW_FRAMES);
                    end
                end else if (start_of_frame) begin
                    slow_timer_d = slow_timer_q - 8'd1;
                    if (slow_timer_q == 8'd1)
                        state_d = PLAY;
                end
            end
            HIT: begin
                if (start_of_frame) begin
                    hit_timer_d = hit_timer_q - 8'd1;
                    if (hit_timer_q == 8'd1) begin
                        if (lives_q == 3'd0) begin
                            state_d = OVER;
                        end else begin
                            state_d        = PLAY;
                            invuln_timer_d = 8'(INVULN_FRAMES);
                        end
                    end
                end
            end
            OVER: begin
                if (start_edge)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            score_q        <= 16'd0;
            lives_q        <= 3'(LIVES);
            slow_left_q    <= 4'(SLOW_BUDGET);
            slow_timer_q   <= 8'd0;
            hit_timer_q    <= 8'd0;
            invuln_timer_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            slow_left_q    <= slow_left_d;
            slow_timer_q   <= slow_timer_d;
            hit_timer_q    <= hit_timer_d;
            invuln_timer_q <= invuln_timer_d;
        end
        // Edge-detect copies track inputs in reset too, so no false edge on release
        start_key_q <= start_key;
        slow_key_q  <= slow_key;
        destr1_q    <= destructed_building_1;
        destr2_q    <= destructed_building_2;
        stage_q     <= stage;
    end

    assign slow_down = (state_q == SLOW);
    assign freeze    = (state_q == IDLE) || (state_q == HIT) || (state_q == OVER);
    assign game_over = (state_q == OVER);
    assign score     = score_q;
    assign lives     = lives_q;
    assign slow_left = slow_left_q;
    assign state     = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flappy_game_ctrl
// Directed bench: a vector table for game start and scoring, then hand-written
// sequences for slow-motion timing, hits, invulnerability, game over,
// score saturation and reset mid-slow.
// ---------------------------------------------------------------------------
module tb_flappy_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_of_frame, start_key, slow_key;
    logic [31:0] stage;
    logic        coll_b, coll_g, d1, d2;
    logic        slow_down, freeze, game_over;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [3:0]  slow_left;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    flappy_game_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_of_frame          (start_of_frame),
        .start_key               (start_key),
        .slow_key                (slow_key),
        .stage                   (stage),
        .collision_bird_building (coll_b),
        .collision_bird_ground   (coll_g),
        .destructed_building_1   (d1),
        .destructed_building_2   (d2),
        .slow_down               (slow_down),
        .freeze                  (freeze),
        .game_over               (game_over),
        .score                   (score),
        .lives                   (lives),
        .slow_left               (slow_left),
        .state                   (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, slow, d1, d2;
        logic [31:0] stage;
        logic [2:0]  st;
        logic [15:0] score;
        logic [2:0]  lives;
        logic [3:0]  sl;
        logic        sd, fz, go;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            start_of_frame = 1'b1;
            clk1();
            start_of_frame = 1'b0;
            clk1();
        end
    endtask

    initial begin
        //            start slow d1 d2 stage  st score lives sl sd fz go
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 16'd0,  3'd3, 4'd3, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd1, 16'd0,  3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 3'd1, 16'd1,  3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 3'd1, 16'd2,  3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 3'd1, 16'd13, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 3'd1, 16'd13, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 3'd1, 16'd13, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 3'd1, 16'd18, 3'd3, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 3'd2, 16'd18, 3'd3, 4'd2, 1'b1, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 3'd2, 16'd19, 3'd3, 4'd2, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; start_of_frame = 1'b0; start_key = 1'b0; slow_key = 1'b0;
        stage = 32'd0; coll_b = 1'b0; coll_g = 1'b0; d1 = 1'b0; d2 = 1'b0;
        clk1();
        clk1();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_key = vt[i].start; slow_key = vt[i].slow;
            d1 = vt[i].d1; d2 = vt[i].d2; stage = vt[i].stage;
            clk1();
            chk($sformatf("v%0d state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("v%0d score", i), 32'(score), 32'(vt[i].score));
            chk($sformatf("v%0d lives", i), 32'(lives), 32'(vt[i].lives));
            chk($sformatf("v%0d slow_left", i), 32'(slow_left), 32'(vt[i].sl));
            chk($sformatf("v%0d slow_down", i), 32'(slow_down), 32'(vt[i].sd));
            chk($sformatf("v%0d freeze", i), 32'(freeze), 32'(vt[i].fz));
            chk($sformatf("v%0d game_over", i), 32'(game_over), 32'(vt[i].go));
        end

        // First slow period: exactly 120 frame pulses
        frames(119);
        chk("slow1 at 119", 32'(state), 32'd2);
        frames(1);
        chk("slow1 at 120", 32'(state), 32'd1);
        chk("slow1 sd off", 32'(slow_down), 32'd0);

        slow_key = 1'b1; clk1(); slow_key = 1'b0;
        chk("slow2 enter", 32'(state), 32'd2);
        chk("slow2 left", 32'(slow_left), 32'd1);
        frames(119);
        chk("slow2 at 119", 32'(state), 32'd2);
        frames(1);
        chk("slow2 at 120", 32'(state), 32'd1);

        // Third slow, then a hit during it
        slow_key = 1'b1; clk1(); slow_key = 1'b0;
        chk("slow3 enter", 32'(state), 32'd2);
        chk("slow3 left", 32'(slow_left), 32'd0);
        coll_b = 1'b1; clk1();
        chk("hit1 state", 32'(state), 32'd3);
        chk("hit1 lives", 32'(lives), 32'd2);
        chk("hit1 freeze", 32'(freeze), 32'd1);
        chk("hit1 slow_down", 32'(slow_down), 32'd0);
        frames(59);
        chk("hit1 at 59", 32'(state), 32'd3);
        frames(1);
        chk("hit1 resume", 32'(state), 32'd1);

        // Collision held through invulnerability window
        frames(89);
        chk("invuln 89", 32'(state), 32'd1);
        chk("invuln 89 lives", 32'(lives), 32'd2);
        frames(1);
        chk("hit2 state", 32'(state), 32'd3);
        chk("hit2 lives", 32'(lives), 32'd1);
        coll_b = 1'b0;
        frames(60);
        chk("hit2 resume", 32'(state), 32'd1);

        // Slow budget exhausted: edge ignored
        slow_key = 1'b1; clk1(); slow_key = 1'b0;
        chk("slow4 ignored", 32'(state), 32'd1);
        chk("slow4 left", 32'(slow_left), 32'd0);

        // Third hit via ground collision -> game over
        coll_g = 1'b1;
        frames(89);
        chk("invuln2 89", 32'(state), 32'd1);
        frames(1);
        chk("hit3 state", 32'(state), 32'd3);
        chk("hit3 lives", 32'(lives), 32'd0);
        frames(59);
        chk("hit3 at 59", 32'(state), 32'd3);
        frames(1);
        chk("over state", 32'(state), 32'd4);
        chk("over game_over", 32'(game_over), 32'd1);
        chk("over freeze", 32'(freeze), 32'd1);
        coll_g = 1'b0;

        start_key = 1'b1; clk1();
        chk("over->idle", 32'(state), 32'd0);
        chk("idle lives hold", 32'(lives), 32'd0);
        chk("idle score hold", 32'(score), 32'd19);
        start_key = 1'b0; clk1();
        start_key = 1'b1; clk1(); start_key = 1'b0;
        chk("restart state", 32'(state), 32'd1);
        chk("restart lives", 32'(lives), 32'd3);
        chk("restart score", 32'(score), 32'd0);
        chk("restart slow_left", 32'(slow_left), 32'd3);

        // Score saturation
        for (int i = 0; i < 65533; i++) begin
            stage = stage + 32'd1;
            clk1();
        end
        chk("score FFFD", 32'(score), 32'hFFFD);
        stage = stage + 32'd1; clk1();
        chk("score FFFE", 32'(score), 32'hFFFE);
        d1 = 1'b0; clk1();
        stage = stage + 32'd1; d1 = 1'b1; clk1();
        chk("score sat", 32'(score), 32'hFFFF);
        stage = stage + 32'd1; clk1();
        chk("score sat hold", 32'(score), 32'hFFFF);

        // Reset in the middle of a slow period
        slow_key = 1'b1; clk1(); slow_key = 1'b0;
        chk("slow5 enter", 32'(state), 32'd2);
        frames(70);
        chk("slow5 timer", 32'(dut.slow_timer_q), 32'd50);
        start_key = 1'b1; reset = 1'b1; clk1();
        chk("rst state", 32'(state), 32'd0);
        chk("rst slow_down", 32'(slow_down), 32'd0);
        chk("rst slow_timer", 32'(dut.slow_timer_q), 32'd0);
        chk("rst hit_timer", 32'(dut.hit_timer_q), 32'd0);
        chk("rst invuln", 32'(dut.invuln_timer_q), 32'd0);
        chk("rst score", 32'(score), 32'd0);
        chk("rst lives", 32'(lives), 32'd3);
        chk("rst slow_left", 32'(slow_left), 32'd3);
        reset = 1'b0;
        clk1(); clk1(); clk1();
        chk("held key no start", 32'(state), 32'd0);
        start_key = 1'b0; clk1();
        start_key = 1'b1; clk1();
        chk("fresh edge start", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Top-level game sequencer for the buildings datapath.
- Runs the game state machine: idle, play, slow-motion, hit, game over.
- Drives slow_down into the buildings unit, and freeze to the bird and building movers.
- Tracks lives, score and slow-motion budget from the stage count, collision and destruction flags.
- Sits between the keyboard/frame-tick logic and the buildings/bird units.

Parameters:
LIVES, 3, lives loaded at game start (1..7)
SLOW_BUDGET, 3, slow-motion uses per game (0..15)
SLOW_FRAMES, 120, frames a slow-motion period lasts (>=1)
HIT_FRAMES, 60, frames the game freezes after a hit (>=1)
INVULN_FRAMES, 90, frames collisions are ignored after resuming from a hit
DESTROY_BONUS, 5, score added per destroyed building

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start_of_frame  in  1  one-cycle pulse per video frame
start_key  in  1  level, already synchronized
slow_key  in  1  level, already synchronized
stage  in  32  stage count from the buildings unit
collision_bird_building  in  1  level, bird overlaps a building
collision_bird_ground  in  1  level, bird touches ground or ceiling
destructed_building_1  in  1  level, building 1 destroyed
destructed_building_2  in  1  level, building 2 destroyed
slow_down  out  1  to buildings unit
freeze  out  1  halts bird and building motion
game_over  out  1  game-over indication
score  out  16  current score
lives  out  3  remaining lives
slow_left  out  4  remaining slow-motion uses
state  out  3  IDLE=0, PLAY=1, SLOW=2, HIT=3, OVER=4

Behaviour:
- All registers update on the rising edge of clk.
- Reset (sync, high, any state, mid-timer included):
  - state=IDLE, score=0, lives=LIVES, slow_left=SLOW_BUDGET.
  - Timers cleared; edge-detect registers set to current inputs (no false edge after reset).
- Edge detection: start_key, slow_key, destructed_building_1 and destructed_building_2 are rising-edge detected against a 1-cycle-delayed copy. stage change = stage != stage_d.
- Decoded outputs, combinational from state:
  - slow_down=1 only in SLOW.
  - freeze=1 in IDLE, HIT and OVER.
  - game_over=1 only in OVER.
- hit = (collision_bird_building | collision_bird_ground) & (invuln_timer==0). Both are levels; only the state machine acts on them.
- IDLE: start_key edge -> PLAY. Same edge loads score=0, lives=LIVES, slow_left=SLOW_BUDGET, invuln_timer=0.
- PLAY, in priority order:
  - hit -> HIT, lives decrements (saturating at 0), hit_timer=HIT_FRAMES.
  - Else slow_key edge with slow_left>0 -> SLOW, slow_left decrements, slow_timer=SLOW_FRAMES.
  - slow_key edge with slow_left==0 is ignored.
- SLOW:
  - hit -> HIT, same actions as in PLAY; remaining slow time is discarded. Hit has priority over timeout.
  - Otherwise slow_timer decrements on each start_of_frame.
  - If slow_timer==1 and start_of_frame -> PLAY. slow_down therefore stays high for exactly SLOW_FRAMES frame pulses.
- HIT:
  - hit_timer decrements on start_of_frame.
  - On expiry (timer==1 and start_of_frame): lives==0 -> OVER; else -> PLAY with invuln_timer=INVULN_FRAMES.
- invuln_timer decrements on start_of_frame in PLAY/SLOW until 0.
- OVER: start_key edge -> IDLE. Score, lives and slow_left hold until the next IDLE->PLAY load.
- Score changes only in PLAY or SLOW, evaluated on the current state:
  - +1 per cycle with a stage change.
  - +DESTROY_BONUS per destructed edge; both edges in one cycle add 2*DESTROY_BONUS.
  - Stage and destroy increments in the same cycle sum.
  - Saturates at 16'hFFFF, no wrap.
  - A stage change in the same cycle as a hit still scores.
- Timers are 8-bit; parameters above 255 are illegal.
- Latency: every output reflects an input event one clock after the event cycle.
- Undefined state encodings (5..7) -> IDLE next cycle.

Test Plan:
- Reset then start_key edge -> state=1, lives=3, score=0, slow_left=3, freeze=0 one clock later.
- In PLAY, slow_key edge -> state=2, slow_down=1, slow_left=2. After exactly 120 start_of_frame pulses -> state=1, slow_down=0. Repeat 3 times; a 4th slow_key edge leaves state=1.
- In SLOW, assert collision_bird_building -> state=3, lives=2, freeze=1. After 60 frames -> state=1. Collision held 89 frames -> no new hit. Collision still held at frame 90 -> HIT again, lives=1.
- Stage increments 3 times plus destructed_building_1 and destructed_building_2 rising in the same cycle -> score=13. With score preset near 16'hFFFE, further events saturate at 16'hFFFF.
- Three hits -> lives=0, state=4, game_over=1 after the third HIT timeout. start_key edge -> IDLE; next edge -> PLAY with lives=3, score=0.
- Assert reset mid-SLOW with slow_timer=50 -> next clock state=0, slow_down=0, timers=0. Holding start_key high through reset release gives no transition until a fresh rising edge.
